traf_phase_sched: RTL
=====================

// Module: traf_phase_sched
// PURPOSE
//  Phase scheduler for the two-road traffic-light controller. Sequences the light phases,
//  times each phase from an internal one-second tick and shortens a green on a cross-road
//  request. Drives the six lamp outputs and a 2-digit BCD countdown for the 7-seg scanner.
//  Sits between the top level (Clk/Reset, request buttons) and the display/lamp drivers.
// PARAMETERS
//  CLK_DIV    50000000  Clk cycles per second tick (>=2)
//  G1_TIME    25        road-1 green duration, seconds (1..99)
//  G2_TIME    20        road-2 green duration, seconds (1..99)
//  Y_TIME     5         yellow duration, seconds (1..99)
//  AR_TIME    2         all-red clearance duration, seconds (1..99)
//  MIN_GREEN  5         green remaining after request truncation (1..99)
// PORTS
//  Clk       in   1  system clock
//  Reset     in   1  synchronous, active-high reset
//  Req1      in   1  request for road 1 (level, sampled each Clk)
//  Req2      in   1  request for road 2 (level, sampled each Clk)
//  Red1/Yellow1/Green1  out  1 each  road-1 lamps
//  Red2/Yellow2/Green2  out  1 each  road-2 lamps
//  Cnt_tens  out  4  BCD tens digit of seconds remaining
//  Cnt_ones  out  4  BCD ones digit of seconds remaining
//  Phase     out  3  current phase code (see BEHAVIOUR)
//  Sec_tick  out  1  one-Clk pulse each second
// BEHAVIOUR
//  - States/codes: G1=0, Y1=1, AR1=2, G2=3, Y2=4, AR2=5; order G1>Y1>AR1>G2>Y2>AR2>G1.
//  - Lamps are decoded from the state register only; no combinational path from inputs.
//    G1: Green1,Red2. Y1: Yellow1,Red2. AR1/AR2: Red1,Red2. G2: Red1,Green2. Y2: Red1,Yellow2.
//  - Prescaler counts 0..CLK_DIV-1; Sec_tick=1 in the cycle it equals CLK_DIV-1, then wraps to 0.
//  - Countdown is a BCD pair. Entering a state loads that state's duration, so the display
//    shows T..1. On Sec_tick: if count==01, go to next state and load its duration in the same
//    edge; otherwise decrement (ones==0 -> ones=9, tens-1).
//  - Truncation: in G1, Req2=1 while count > MIN_GREEN loads MIN_GREEN on the next edge.
//    G2/Req1 works the same way. Requests in any other state, or with count <= MIN_GREEN,
//    are ignored and not remembered.
//  - Truncation and Sec_tick in the same cycle: truncation wins (load MIN_GREEN, no decrement).
//  - Reset (any time, including mid-phase): state G1, count=G1_TIME, prescaler=0, Sec_tick=0,
//    Green1=Red2=1, all other lamps 0, Phase=0. Prescaler restarts from 0.
//  - Parameter-to-BCD conversion (/10, %10) is done at elaboration; no runtime divider.
// CONFIGURATION
//  TRAF_EMERG_EN defined: adds input port Emerg (1 bit) and state HOLD (Phase=6, Red1=Red2=1).
//    - Emerg=1 in G1/G2: go to Y1/Y2 next edge and load Y_TIME.
//    - Emerg=1 in Y/AR: those phases run normally.
//    - At the end of AR1/AR2 with Emerg=1: enter HOLD, count=00.
//    - Stay in HOLD while Emerg=1. On release, go to G1 and load G1_TIME.
//    - Emerg has priority over truncation.
//  TRAF_EMERG_EN undefined: no Emerg port, no HOLD state; Phase 6/7 unreachable.
// STRUCTURE
//  - Package traf_pkg: phase code localparams (PH_G1..PH_HOLD), lamp-vector constants,
//    BCD-decrement function.
//  - Sub-module traf_sec_prescaler (CLK_DIV param; Clk, Reset -> Sec_tick).
//  - FSM, BCD counter and lamp decode stay in this module.
// TESTING  (bench overrides CLK_DIV=4; other parameters at default)
//  1. Release reset -> Green1=Red2=1, count 25. After 100 Clk -> Phase=1, Yellow1=1, count 05.
//  2. Free run -> full cycle takes 59 ticks (236 Clk); Phase returns to 0 with count 25.
//     Each transition coincides with Sec_tick.
//  3. G1 at count 20, pulse Req2 1 Clk -> count 05 next edge. G1 at count 03, Req2 -> no change.
//     Req1 during G1 -> no change.
//  4. Count 10 at Sec_tick -> 09 (tens 1->0, ones 0->9). Truncation coincident with tick -> 05.
//  5. Assert Reset for 1 Clk mid-Y2 (count 03) -> next edge Phase=0, count 25, Sec_tick after 4 Clk.
//  6. With TRAF_EMERG_EN: Emerg=1 in G2 count 12 -> Y2/05, then AR2/02, then HOLD (Phase 6).
//     Drop Emerg -> G1/25.

Source files
------------

// File: rtl/traf_pkg.sv
// Shared definitions for the traffic phase scheduler: phase codes, lamp patterns, BCD helpers.
// Works with or without TRAF_EMERG_EN; the HOLD code exists here either way but is only reachable when it is defined.
package traf_pkg;

    localparam logic [2:0] PH_G1   = 3'd0;
    localparam logic [2:0] PH_Y1   = 3'd1;
    localparam logic [2:0] PH_AR1  = 3'd2;
    localparam logic [2:0] PH_G2   = 3'd3;
    localparam logic [2:0] PH_Y2   = 3'd4;
    localparam logic [2:0] PH_AR2  = 3'd5;
    localparam logic [2:0] PH_HOLD = 3'd6;

    typedef enum logic [2:0] {
        ST_G1   = PH_G1,
        ST_Y1   = PH_Y1,
        ST_AR1  = PH_AR1,
        ST_G2   = PH_G2,
        ST_Y2   = PH_Y2,
        ST_AR2  = PH_AR2,
        ST_HOLD = PH_HOLD
    } state_t;

    // Lamp vector order: {red1, yellow1, green1, red2, yellow2, green2}
    localparam logic [5:0] LAMP_G1  = 6'b001_100;
    localparam logic [5:0] LAMP_Y1  = 6'b010_100;
    localparam logic [5:0] LAMP_RED = 6'b100_100;
    localparam logic [5:0] LAMP_G2  = 6'b100_001;
    localparam logic [5:0] LAMP_Y2  = 6'b100_010;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd2_t;

    function automatic bcd2_t to_bcd(input int v);
        bcd2_t r;
        r.tens = 4'(v / 10);
        r.ones = 4'(v % 10);
        return r;
    endfunction

    function automatic bcd2_t bcd_dec(input bcd2_t v);
        bcd2_t r;
        if (v.ones == 4'd0) begin
            r.ones = 4'd9;
            r.tens = v.tens - 4'd1;
        end else begin
            r.ones = v.ones - 4'd1;
            r.tens = v.tens;
        end
        return r;
    endfunction

    function automatic logic [5:0] lamps_of(input state_t s);
        case (s)
            ST_G1:   return LAMP_G1;
            ST_Y1:   return LAMP_Y1;
            ST_G2:   return LAMP_G2;
            ST_Y2:   return LAMP_Y2;
            default: return LAMP_RED;
        endcase
    endfunction

endpackage

// File: rtl/traf_sec_prescaler.sv
// One-second tick generator: counts 0..CLK_DIV-1 and pulses Sec_tick on the last count.
module traf_sec_prescaler #(
    parameter int CLK_DIV = 50000000
) (
    input  logic Clk,
    input  logic Reset,
    output logic Sec_tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign Sec_tick = (cnt == LAST);

endmodule

// File: rtl/traf_phase_sched.sv
// Two-road traffic phase scheduler with BCD countdown and request truncation of greens.
// Define TRAF_EMERG_EN to add the Emerg input and the all-red HOLD phase.
module traf_phase_sched
    import traf_pkg::*;
#(
    parameter int CLK_DIV   = 50000000,
    parameter int G1_TIME   = 25,
    parameter int G2_TIME   = 20,
    parameter int Y_TIME    = 5,
    parameter int AR_TIME   = 2,
    parameter int MIN_GREEN = 5
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Req1,
    input  logic       Req2,
`ifdef TRAF_EMERG_EN
    input  logic       Emerg,
`endif
    output logic       Red1,
    output logic       Yellow1,
    output logic       Green1,
    output logic       Red2,
    output logic       Yellow2,
    output logic       Green2,
    output logic [3:0] Cnt_tens,
    output logic [3:0] Cnt_ones,
    output logic [2:0] Phase,
    output logic       Sec_tick
);

    localparam bcd2_t G1_BCD  = to_bcd(G1_TIME);
    localparam bcd2_t G2_BCD  = to_bcd(G2_TIME);
    localparam bcd2_t Y_BCD   = to_bcd(Y_TIME);
    localparam bcd2_t AR_BCD  = to_bcd(AR_TIME);
    localparam bcd2_t MIN_BCD = to_bcd(MIN_GREEN);
    localparam bcd2_t ONE_BCD = to_bcd(1);

    state_t     state, state_nx;
    bcd2_t      cnt, cnt_nx;
    logic [5:0] lamps;
    logic       trunc;

    traf_sec_prescaler #(.CLK_DIV(CLK_DIV)) u_presc (
        .Clk      (Clk),
        .Reset    (Reset),
        .Sec_tick (Sec_tick)
    );

    function automatic state_t next_of(input state_t s);
        case (s)
            ST_G1:   return ST_Y1;
            ST_Y1:   return ST_AR1;
            ST_AR1:  return ST_G2;
            ST_G2:   return ST_Y2;
            ST_Y2:   return ST_AR2;
            default: return ST_G1;
        endcase
    endfunction

    function automatic bcd2_t dur_of(input state_t s);
        case (s)
            ST_Y1, ST_Y2:   return Y_BCD;
            ST_AR1, ST_AR2: return AR_BCD;
            ST_G2:          return G2_BCD;
            default:        return G1_BCD;
        endcase
    endfunction

    // Valid BCD pairs order the same way as their packed 8-bit value.
    assign trunc = ((state == ST_G1 && Req2) || (state == ST_G2 && Req1))
                   && (8'(cnt) > 8'(MIN_BCD));

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
`ifdef TRAF_EMERG_EN
        if (Emerg && (state == ST_G1 || state == ST_G2)) begin
            state_nx = next_of(state);
            cnt_nx   = Y_BCD;
        end else if (state == ST_HOLD) begin
            if (!Emerg) begin
                state_nx = ST_G1;
                cnt_nx   = G1_BCD;
            end
        end else
`endif
        if (trunc) begin
            cnt_nx = MIN_BCD;
        end else if (Sec_tick) begin
            if (cnt == ONE_BCD) begin
`ifdef TRAF_EMERG_EN
                if (Emerg && (state == ST_AR1 || state == ST_AR2)) begin
                    state_nx = ST_HOLD;
                    cnt_nx   = '0;
                end else
`endif
                begin
                    state_nx = next_of(state);
                    cnt_nx   = dur_of(next_of(state));
                end
            end else begin
                cnt_nx = bcd_dec(cnt);
            end
        end
    end

    // Lamps are registered from the next state so they stay aligned with the state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_G1;
            cnt   <= G1_BCD;
            lamps <= LAMP_G1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            lamps <= lamps_of(state_nx);
        end
    end

    assign {Red1, Yellow1, Green1, Red2, Yellow2, Green2} = lamps;
    assign Cnt_tens = cnt.tens;
    assign Cnt_ones = cnt.ones;
    assign Phase    = state;

endmodule
